// File: rtl/ifetch_unit.sv
// ifetch_unit -- instruction fetch stage feeding data_path.instr.
//   Issues one word fetch at a time to a variable-latency instruction memory
//   (imem_req held until imem_ack). Fetched words and their PCs go into a
//   DEPTH-entry prefetch FIFO whose head is offered with valid/ready. A branch
//   redirect flushes the FIFO and restarts fetching at the new PC. A fetch that
//   is in flight when the redirect arrives is completed and its data dropped.
// Parameters: DEPTH (power of 2, >=2), RESET_PC (first fetch address).
// Ports:
//   clk, reset (async, active low)
//   redirect, redirect_pc            -- branch redirect from the datapath
//   imem_req, imem_addr              -- fetch request / word address
//   imem_ack, imem_rdata             -- fetch completion / data
//   instr, instr_pc, instr_valid     -- FIFO head to the datapath
//   instr_ready                      -- datapath consumes the head
// Optional macro IFETCH_PERF_EN adds perf_stall / perf_flush saturating counters.
module ifetch_unit #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
`ifdef IFETCH_PERF_EN
   output logic [31:0] perf_stall,
   output logic [31:0] perf_flush,
`endif
   input  logic        instr_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t        state, state_nx;
   logic [31:0]   fetch_pc, drop_addr;
   logic [31:0]   pc_mem  [DEPTH];
   logic [31:0]   ins_mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count, count_nx;
   logic [31:0]   hold_pc, hold_ins;
   logic          push, pop;

   // a redirect overrides both push and pop in the same cycle
   assign push     = (state == WAIT) && imem_ack && !redirect;
   assign pop      = (count != '0) && instr_ready && !redirect;
   assign count_nx = redirect ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (!redirect && count < FULL) state_nx = WAIT;
         WAIT: begin
            if (redirect)      state_nx = imem_ack ? IDLE : DROP;
            else if (imem_ack) state_nx = (count_nx < FULL) ? WAIT : IDLE;
         end
         DROP: if (imem_ack) state_nx = (!redirect && count_nx < FULL) ? WAIT : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // outputs; in WAIT fetch_pc is the address of the outstanding fetch, in
   // DROP fetch_pc already points at the redirect target so the stale
   // address is kept separately
   always_comb begin
      imem_req    = (state != IDLE);
      imem_addr   = (state == DROP) ? drop_addr : fetch_pc;
      instr_valid = (count != '0);
      instr       = instr_valid ? ins_mem[rd_ptr] : hold_ins;
      instr_pc    = instr_valid ? pc_mem[rd_ptr]  : hold_pc;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc  <= RESET_PC;
         drop_addr <= RESET_PC;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         hold_pc   <= '0;
         hold_ins  <= '0;
      end else begin
         count <= count_nx;
         if (state == WAIT && redirect && !imem_ack) drop_addr <= fetch_pc;
         if (redirect)  fetch_pc <= redirect_pc & ~32'h3;
         else if (push) fetch_pc <= fetch_pc + 32'd4;
         if (redirect) begin
            rd_ptr <= wr_ptr;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
         end
         // remember the head so instr/instr_pc stay put once the FIFO empties
         if (count != '0) begin
            hold_pc  <= pc_mem[rd_ptr];
            hold_ins <= ins_mem[rd_ptr];
         end
      end
   end

   // storage needs no reset: it is only visible while count says it is valid
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]  <= fetch_pc;
         ins_mem[wr_ptr] <= imem_rdata;
      end
   end

`ifdef IFETCH_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_stall <= '0;
         perf_flush <= '0;
      end else begin
         if (instr_ready && !instr_valid && perf_stall != 32'hFFFF_FFFF)
            perf_stall <= perf_stall + 32'd1;
         if (redirect && perf_flush != 32'hFFFF_FFFF)
            perf_flush <= perf_flush + 32'd1;
      end
   end
`endif

endmodule
